y86_prog_loader: RTL

Synthesizable program loader for the Y86-64 single-cycle core. It accepts a byte stream over a valid/ready handshake and parses it as one or more address/length segments. Payload bytes are written into the core's byte-wide instruction memory, and the core is held in reset until the whole image has loaded and its checksum matches. It replaces hierarchical testbench pokes into `fetch_stage.instr_mem` with a real load path, usable from benches and from a UART/JTAG front end.

---
 rtl/y86_prog_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/y86_prog_loader.sv
// Streaming program loader for the Y86-64 core: parses tagged address/length segments
// into instruction memory and releases the core from reset once the checksum matches.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_TAG   | waiting for a segment tag (0x5A) or the end tag (0xA5)
// ST_ADDR0 | receiving start address, low byte
// ST_ADDR1 | receiving start address, high byte
// ST_LEN0  | receiving segment length, low byte
// ST_LEN1  | receiving segment length, high byte
// ST_DATA  | receiving payload bytes, one memory write per byte
// ST_CKSUM | receiving the image checksum byte
// ST_DONE  | image loaded and verified, core released
// ST_ERROR | parse/range/checksum failure, err_o holds the cause
module y86_prog_loader #(
   parameter int ADDR_W    = 8,
   parameter int SEG_CNT_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [7:0]           s_data_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   input  logic                 reload_i,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [7:0]           mem_wdata_o,
   output logic                 cpu_rst_n_o,
   output logic                 done_o,
   output logic [1:0]           err_o,
   output logic [SEG_CNT_W-1:0] seg_cnt_o
);

   typedef enum logic [3:0] {
      ST_TAG,
      ST_ADDR0,
      ST_ADDR1,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_CKSUM,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam logic [7:0]  TAG_SEG   = 8'h5A;
   localparam logic [7:0]  TAG_END   = 8'hA5;
   localparam logic [1:0]  ERR_TAG   = 2'd1;
   localparam logic [1:0]  ERR_RANGE = 2'd2;
   localparam logic [1:0]  ERR_CKSUM = 2'd3;
   // one extra bit so the address can run past 0xFFFF without wrapping back into range
   localparam logic [16:0] MEM_DEPTH = 17'(1) << ADDR_W;

   state_t               state;
   logic [16:0]          cur_addr;
   logic [15:0]          remain;
   logic [7:0]           cksum;
   logic                 accept;
   logic [SEG_CNT_W-1:0] seg_inc;

   assign accept  = s_valid_i && s_ready_o;
   assign seg_inc = (&seg_cnt_o) ? seg_cnt_o : seg_cnt_o + SEG_CNT_W'(1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= ST_TAG;
         s_ready_o   <= 1'b1;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         cpu_rst_n_o <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 2'd0;
         seg_cnt_o   <= '0;
         cur_addr    <= '0;
         remain      <= '0;
         cksum       <= '0;
      end else begin
         mem_we_o    <= 1'b0;
         // done_o leads the core release by one cycle so the last write lands first
         cpu_rst_n_o <= done_o;
         if (reload_i) begin
            state       <= ST_TAG;
            s_ready_o   <= 1'b1;
            cksum       <= '0;
            seg_cnt_o   <= '0;
            err_o       <= 2'd0;
            done_o      <= 1'b0;
            cpu_rst_n_o <= 1'b0;
         end else if (accept) begin
            case (state)
               ST_TAG: begin
                  if (s_data_i == TAG_SEG) begin
                     state <= ST_ADDR0;
                  end else if (s_data_i == TAG_END) begin
                     state <= ST_CKSUM;
                  end else begin
                     state     <= ST_ERROR;
                     s_ready_o <= 1'b0;
                     err_o     <= ERR_TAG;
                  end
               end
               ST_ADDR0: begin
                  cur_addr[7:0] <= s_data_i;
                  state         <= ST_ADDR1;
               end
               ST_ADDR1: begin
                  cur_addr[16:8] <= {1'b0, s_data_i};
                  state          <= ST_LEN0;
               end
               ST_LEN0: begin
                  remain[7:0] <= s_data_i;
                  state       <= ST_LEN1;
               end
               ST_LEN1: begin
                  remain[15:8] <= s_data_i;
                  if ({s_data_i, remain[7:0]} == 16'd0) begin
                     state     <= ST_TAG;
                     seg_cnt_o <= seg_inc;
                  end else begin
                     state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (cur_addr >= MEM_DEPTH) begin
                     state     <= ST_ERROR;
                     s_ready_o <= 1'b0;
                     err_o     <= ERR_RANGE;
                  end else begin
                     mem_we_o    <= 1'b1;
                     mem_addr_o  <= cur_addr[ADDR_W-1:0];
                     mem_wdata_o <= s_data_i;
                     cksum       <= cksum + s_data_i;
                     cur_addr    <= cur_addr + 17'd1;
                     remain      <= remain - 16'd1;
                     if (remain == 16'd1) begin
                        state     <= ST_TAG;
                        seg_cnt_o <= seg_inc;
                     end
                  end
               end
               ST_CKSUM: begin
                  s_ready_o <= 1'b0;
                  if (s_data_i == cksum) begin
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= ST_ERROR;
                     err_o <= ERR_CKSUM;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
